// File: rtl/lfsr_age_arbiter.sv
// lfsr_age_arbiter: one-hot arbiter with LFSR-randomized rotating priority and an age-based starvation override
module lfsr_age_arbiter #(
  parameter int NUM_REQS  = 4,
  parameter int K         = 100,
  parameter int URGENT_TH = K - NUM_REQS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [7:0]          lfsr_seed,
  input  logic                seed_load,
  input  logic [NUM_REQS-1:0] req,
  output logic [NUM_REQS-1:0] grant,
  output logic                urgent_mode,
  output logic                starve_err
);
  localparam int AGE_W = $clog2(K + 1);
  localparam int IDX_W = $clog2(NUM_REQS);
  localparam logic [AGE_W-1:0] TH   = AGE_W'(URGENT_TH);
  localparam logic [AGE_W-1:0] KMAX = AGE_W'(K);
  localparam logic [AGE_W-1:0] KM1  = AGE_W'(K - 1);

  typedef enum logic {RAND, URGENT} mode_t;

  if (K <= 2 * NUM_REQS) begin : g_bad_k
    $error("lfsr_age_arbiter: K must exceed 2*NUM_REQS");
  end

  mode_t               state_q, state_d;
  logic [7:0]          lfsr_q, lfsr_d;
  logic [AGE_W-1:0]    age_q [NUM_REQS];
  logic [AGE_W-1:0]    age_d [NUM_REQS];
  logic [NUM_REQS-1:0] gnt_d, near_k;
  logic [IDX_W-1:0]    best, pick, idx, start;
  logic [AGE_W-1:0]    best_age;
  logic                any_urg;

  assign start = lfsr_q[IDX_W-1:0];
  assign lfsr_d = seed_load ? (lfsr_seed == 8'h00 ? 8'h01 : lfsr_seed)
                            : ({1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? 8'hB8 : 8'h00));

  // oldest urgent requester wins; strict '>' keeps the lowest index on ties
  always_comb begin
    any_urg = 1'b0;
    best = '0;
    best_age = '0;
    for (int i = 0; i < NUM_REQS; i++)
      if (req[i] && age_q[i] >= TH && (!any_urg || age_q[i] > best_age)) begin
        any_urg = 1'b1;
        best = IDX_W'(i);
        best_age = age_q[i];
      end
  end

  // rotating search from the LFSR start; descending loop so the first hit in search order wins
  always_comb begin
    pick = '0;
    idx = '0;
    for (int j = NUM_REQS - 1; j >= 0; j--) begin
      idx = start + IDX_W'(j);
      pick = req[idx] ? idx : pick;
    end
  end

  // next grant, mode and ages from the current request/age snapshot
  always_comb begin
    gnt_d = any_urg ? NUM_REQS'(1) << best : (|req ? NUM_REQS'(1) << pick : '0);
    state_d = any_urg ? URGENT : RAND;
    for (int i = 0; i < NUM_REQS; i++) begin
      age_d[i] = (req[i] && !gnt_d[i]) ? (age_q[i] == KMAX ? KMAX : age_q[i] + 1'b1) : '0;
      near_k[i] = age_q[i] >= KM1;
    end
  end

  // state registers, all cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RAND;
      lfsr_q <= 8'h01;
      age_q <= '{default: '0};
      grant <= '0;
      starve_err <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q <= lfsr_d;
      age_q <= age_d;
      grant <= gnt_d;
      starve_err <= starve_err | (|(req & ~gnt_d & near_k));
    end
  end

  assign urgent_mode = (state_q == URGENT);
endmodule

// File: tb/tb_lfsr_age_arbiter.sv
// tb_lfsr_age_arbiter: directed vector bench for lfsr_age_arbiter (K=100 and K=12 instances)
module tb_lfsr_age_arbiter;
  logic       clk = 1'b0, rst_n = 1'b0, seed_load = 1'b0;
  logic [7:0] lfsr_seed = 8'h00;
  logic [3:0] req = 4'h0;
  logic [3:0] g, g12;
  logic       u, u12, se, se12;
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  lfsr_age_arbiter #(.NUM_REQS(4), .K(100)) dut (
    .clk(clk), .rst_n(rst_n), .lfsr_seed(lfsr_seed), .seed_load(seed_load),
    .req(req), .grant(g), .urgent_mode(u), .starve_err(se));

  lfsr_age_arbiter #(.NUM_REQS(4), .K(12)) dut12 (
    .clk(clk), .rst_n(rst_n), .lfsr_seed(lfsr_seed), .seed_load(seed_load),
    .req(req), .grant(g12), .urgent_mode(u12), .starve_err(se12));

  typedef struct {
    logic [3:0] req;
    logic       ld;
    logic [7:0] seed;
    logic [3:0] g;
    logic       u;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_le(input string name, input int act, input int lim);
    checks++;
    if (act > lim || act == 0) begin
      errors++;
      $display("FAIL %s: got %0d required 1..%0d", name, act, lim);
    end
  endtask

  task automatic step(input logic [3:0] r, input logic ld, input logic [7:0] s);
    req = r;
    seed_load = ld;
    lfsr_seed = s;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int gap[4], mx[4], gap12[4], mx12[4], bad;
    logic [7:0] seeds[4];
    logic [3:0] eg;
    logic       eu;
    seeds = '{8'hA5, 8'h01, 8'h5A, 8'hFF};
    tbl[0]  = '{4'h0, 1'b1, 8'h01, 4'h0, 1'b0};
    tbl[1]  = '{4'hF, 1'b0, 8'h00, 4'h2, 1'b0};
    tbl[2]  = '{4'hF, 1'b0, 8'h00, 4'h1, 1'b0};
    tbl[3]  = '{4'hF, 1'b0, 8'h00, 4'h1, 1'b0};
    tbl[4]  = '{4'hA, 1'b0, 8'h00, 4'h8, 1'b0};
    tbl[5]  = '{4'h1, 1'b0, 8'h00, 4'h1, 1'b0};
    tbl[6]  = '{4'h4, 1'b0, 8'h00, 4'h4, 1'b0};
    tbl[7]  = '{4'h0, 1'b0, 8'h00, 4'h0, 1'b0};
    tbl[8]  = '{4'h6, 1'b0, 8'h00, 4'h2, 1'b0};
    tbl[9]  = '{4'h0, 1'b1, 8'hA5, 4'h0, 1'b0};
    tbl[10] = '{4'h8, 1'b0, 8'h00, 4'h8, 1'b0};
    tbl[11] = '{4'h3, 1'b0, 8'h00, 4'h1, 1'b0};
    tbl[12] = '{4'h3, 1'b0, 8'h00, 4'h2, 1'b0};

    // reset and idle
    repeat (2) @(negedge clk);
    chk("rst_grant", g, 0);
    chk("rst_urgent", u, 0);
    chk("rst_starve", se, 0);
    rst_n = 1'b1;
    chk("rst_lfsr", dut.lfsr_q, 8'h01);
    for (int i = 0; i < 4; i++) chk($sformatf("rst_age%0d", i), dut.age_q[i], 0);
    for (int c = 0; c < 10; c++) begin
      step(4'h0, 1'b0, 8'h00);
      chk("idle_grant", g, 0);
      chk("idle_urgent", u, 0);
      chk("idle_starve", se, 0);
    end

    // seed loading, zero seed maps to 01, then one Galois shift
    step(4'h0, 1'b1, 8'h00);
    chk("seed_zero", dut.lfsr_q, 8'h01);
    step(4'h0, 1'b1, 8'hA5);
    chk("seed_a5", dut.lfsr_q, 8'hA5);
    step(4'h0, 1'b0, 8'h00);
    chk("shift_a5", dut.lfsr_q, 8'hEA);

    // directed vector table
    for (int v = 0; v < 13; v++) begin
      step(tbl[v].req, tbl[v].ld, tbl[v].seed);
      chk($sformatf("vec%0d_grant", v), g, tbl[v].g);
      chk($sformatf("vec%0d_urgent", v), u, tbl[v].u);
    end

    // single held requester
    step(4'h0, 1'b0, 8'h00);
    chk("solo_pre", g, 0);
    for (int c = 0; c < 4; c++) begin
      step(4'h4, 1'b0, 8'h00);
      chk($sformatf("solo_grant%0d", c), g, 4'h4);
    end

    // K=12: start pinned to index 0 by reloading seed 04 every cycle
    step(4'h0, 1'b1, 8'h04);
    for (int e = 1; e <= 21; e++) begin
      step(4'hF, 1'b1, 8'h04);
      eg = (e == 9 || e == 18) ? 4'h2 : (e == 10 || e == 19) ? 4'h4 :
           (e == 11 || e == 20) ? 4'h8 : 4'h1;
      eu = (e >= 9 && e <= 11) || (e >= 18 && e <= 20);
      chk($sformatf("urg_e%0d_grant", e), g12, eg);
      chk($sformatf("urg_e%0d_mode", e), u12, eu);
    end
    chk("urg_starve", se12, 0);

    // long runs with all requests held, several seeds
    foreach (seeds[s]) begin
      step(4'h0, 1'b1, seeds[s]);
      bad = 0;
      for (int i = 0; i < 4; i++) begin gap[i] = 0; mx[i] = 0; gap12[i] = 0; mx12[i] = 0; end
      for (int c = 0; c < 2000; c++) begin
        step(4'hF, 1'b0, 8'h00);
        if (!$onehot0(g) || !$onehot0(g12) || g == 0 || g12 == 0) bad++;
        for (int i = 0; i < 4; i++) begin
          gap[i]++;
          gap12[i]++;
          if (g[i]) begin mx[i] = gap[i] > mx[i] ? gap[i] : mx[i]; gap[i] = 0; end
          if (g12[i]) begin mx12[i] = gap12[i] > mx12[i] ? gap12[i] : mx12[i]; gap12[i] = 0; end
        end
      end
      chk($sformatf("run%0h_onehot", seeds[s]), bad, 0);
      for (int i = 0; i < 4; i++) begin
        chk_le($sformatf("run%0h_gap%0d", seeds[s], i), gap[i] > mx[i] ? gap[i] : mx[i], 100);
        chk_le($sformatf("run%0h_gap12_%0d", seeds[s], i), gap12[i] > mx12[i] ? gap12[i] : mx12[i], 12);
      end
      chk($sformatf("run%0h_starve", seeds[s]), se, 0);
      chk($sformatf("run%0h_starve12", seeds[s]), se12, 0);
    end

    // asynchronous reset while a grant is in flight
    step(4'h8, 1'b0, 8'h00);
    chk("pre_rst_grant", g, 4'h8);
    @(posedge clk);
    #2;
    chk("inflight_grant", g, 4'h8);
    rst_n = 1'b0;
    #1;
    chk("async_grant", g, 0);
    chk("async_urgent", u, 0);
    chk("async_grant12", g12, 0);
    chk("async_urgent12", u12, 0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("post_rst_lfsr", dut.lfsr_q, 8'h01);
    chk("post_rst_grant", g, 0);
    step(4'h2, 1'b0, 8'h00);
    chk("post_rst_first", g, 4'h2);
    chk("post_rst_urgent", u, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/lfsr_age_arbiter.md
Name: lfsr_age_arbiter

Overview:
- Shares one resource among NUM_REQS requesters. Grants are one-hot, registered and single-cycle.
- Normal priority is randomized: an 8-bit LFSR picks the starting index of a rotating search.
- Per-requester age counters override the random choice once a request nears the starvation bound K. This guarantees that req[i] |-> ##[1:K] grant[i] holds for every seed.
- Sits in front of the shared datapath and is checked by the team's starvation-bound property module.

Parameters:
NUM_REQS, 4, number of requesters; power of two, 2..16.
K, 100, starvation bound in cycles; must satisfy K > 2*NUM_REQS (elaboration-time $error otherwise).
URGENT_TH, K-NUM_REQS, age at which a request becomes urgent.

Ports:
clk  input  1  clock, all state on posedge
rst_n  input  1  reset, asynchronous, active-low
lfsr_seed  input  8  seed value for LFSR
seed_load  input  1  pulse: load lfsr_seed into LFSR this cycle
req  input  NUM_REQS  level requests, held until granted
grant  output  NUM_REQS  registered one-hot grant, one-cycle pulse
urgent_mode  output  1  registered; current grant was chosen by the age path
starve_err  output  1  sticky; some age counter reached K

Behaviour:
- Reset (async, rst_n=0):
  - grant=0, urgent_mode=0, starve_err=0.
  - All ages=0; LFSR=8'h01; mode state=RAND.
  - Outputs clear immediately on reset, without waiting for a clock edge.
- LFSR:
  - Galois, polynomial x^8+x^6+x^5+x^4+1 (mask 8'hB8); shifts right every cycle.
  - seed_load=1: LFSR <= lfsr_seed, or 8'h01 if lfsr_seed==0. The load takes priority over the shift.
  - LFSR never holds 0.
- Age counters: age[i] is AGE_W=$clog2(K+1) bits wide. On each edge:
  - req[i]=0, or grant[i] issued at this edge: age[i] <= 0.
  - Else if req[i]=1: age[i] <= age[i]+1, saturating at K.
  - A req held after its grant restarts from 0.
- Mode FSM (two states, evaluated combinationally from current ages and req; registered into urgent_mode):
  - RAND: no active req has age >= URGENT_TH.
  - URGENT: at least one active req has age >= URGENT_TH.
  - RAND->URGENT on the first urgent request. URGENT->RAND when no urgent request remains.
- Grant selection:
  - Selection uses req and age sampled at edge t; grant is registered and visible at t+1. Minimum latency is 1 cycle.
  - URGENT: grant the active urgent requester with the largest age; ties go to the lowest index.
  - RAND: start = LFSR[$clog2(NUM_REQS)-1:0]. Search start, start+1, ... modulo NUM_REQS and grant the first active req.
  - No active req: grant=0 and urgent_mode=0.
- Grant rules:
  - $onehot0(grant) always holds.
  - grant[i] at t+1 implies req[i] was 1 at t.
  - The grant lasts exactly one cycle; the next edge re-arbitrates.
- Boundaries:
  - Wrap-around of the rotating search from index NUM_REQS-1 to 0 is required.
  - With all requests urgent, each is served within NUM_REQS cycles. The guarantee is grant within K.
- starve_err:
  - Set when any age reaches K with req still high and no grant at that edge.
  - Cleared only by reset.
  - Never set in correct operation.
- Reset mid-operation: an in-flight grant drops immediately and all history is lost. After release, arbitration restarts with LFSR=8'h01.

Test Plan:
1. Reset, then idle for 10 cycles -> grant=0, urgent_mode=0, starve_err=0, LFSR=8'h01 after reset, ages all 0.
2. seed_load=1 with lfsr_seed=8'h00, then 8'hA5 -> LFSR=8'h01, then 8'hA5; the next cycle shows the Galois-shifted value 8'hEA.
3. Only req[2] rises at edge t and is held -> grant=4'b0100 at t+1 only. req stays high, so the next grant comes 1 cycle later. grant[i] for i!=2 never asserts.
4. NUM_REQS=4, K=100, seed 8'hA5, req=4'hF held for 2000 cycles -> every grant is one-hot, each requester's gap between grants is <=100, starve_err=0. Repeat for seeds 01, 5A, FF.
5. K=12 (URGENT_TH=8), req=4'hF, LFSR seeded so random start favours index 0 -> urgent_mode rises when an age reaches 8. The oldest requester is granted next, with lowest index on ties. No gap exceeds 12 cycles.
6. rst_n pulled low asynchronously mid-cycle while grant=4'b1000 -> grant=0 and urgent_mode=0 before the next edge. After release with req=4'h2, the first grant is 4'b0010 one cycle after the first sampled edge.
